servo_pwm_bank: RTL

SERVO_PWM_BANK -- requirements
Module: servo_pwm_bank

---
 rtl/servo_pwm_bank.sv | 127 ++++++++++++
 1 files changed

// File: rtl/servo_pwm_bank.sv
// Bank of N_CH hobby-servo PWM channels sharing one microsecond frame counter.
// Positions are double-buffered: port writes land in a shadow copy that becomes active at frame end or restart.
module servo_pwm_bank #(
    parameter int CLK_PER_US = 50,
    parameter int PERIOD_US  = 20000,
    parameter int N_CH       = 4,
    parameter int POS_W      = 8,
    parameter int MIN_US     = 1000,
    parameter int STEP_US    = 4,
    localparam int US_W      = $clog2(PERIOD_US),
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [POS_W-1:0]  wr_pos,
    input  logic              wr_chen,
    input  logic              restart,
    output logic [N_CH-1:0]   pwm_out,
    output logic              frame_start,
    output logic              wr_err,
    output logic [US_W-1:0]   cur_us
);

    localparam int PS_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam longint MAX_WIDTH_US =
        longint'(MIN_US) + ((longint'(1) << POS_W) - 1) * longint'(STEP_US);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0] US_LAST  = US_W'(PERIOD_US - 1);
    localparam logic [US_W:0]   MIN_WID  = (US_W + 1)'(MIN_US);
    localparam logic [US_W:0]   STEP_WID = (US_W + 1)'(STEP_US);
    localparam logic [CH_W:0]   N_CH_WID = (CH_W + 1)'(N_CH);

    // The longest pulse must end strictly inside the frame, otherwise the output never drops.
    generate
        if (MAX_WIDTH_US >= longint'(PERIOD_US) || CLK_PER_US < 1 || N_CH < 1) begin : g_bad_params
            $fatal(1, "servo_pwm_bank: illegal parameter combination");
        end
    endgenerate

    logic [PS_W-1:0]            presc_q, presc_d;
    logic [US_W-1:0]            us_q, us_d;
    logic [N_CH-1:0][POS_W-1:0] shd_pos_q, shd_pos_d;
    logic [N_CH-1:0][POS_W-1:0] act_pos_q, act_pos_d;
    logic [N_CH-1:0]            shd_en_q, shd_en_d;
    logic [N_CH-1:0]            act_en_q, act_en_d;
    logic [N_CH-1:0]            pwm_q, pwm_d;
    logic                       frame_start_q, frame_start_d;
    logic                       wr_err_q, wr_err_d;
    logic [N_CH-1:0][US_W:0]    width;
    logic                       tick;
    logic                       frame_end;
    logic                       wr_ok;

    always_comb begin
        tick      = (presc_q == PS_LAST);
        frame_end = tick && (us_q == US_LAST);
        wr_ok     = wr_en && ({1'b0, wr_ch} < N_CH_WID);

        presc_d = tick ? '0 : presc_q + 1'b1;
        us_d    = us_q;
        if (tick) begin
            us_d = (us_q == US_LAST) ? '0 : us_q + 1'b1;
        end
        if (restart) begin
            presc_d = '0;
            us_d    = '0;
        end

        // Active copy is loaded from the shadow as it stood before this edge's write.
        act_pos_d = act_pos_q;
        act_en_d  = act_en_q;
        if (restart || frame_end) begin
            act_pos_d = shd_pos_q;
            act_en_d  = shd_en_q;
        end

        shd_pos_d = shd_pos_q;
        shd_en_d  = shd_en_q;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_ok && (wr_ch == CH_W'(i))) begin
                shd_pos_d[i] = wr_pos;
                shd_en_d[i]  = wr_chen;
            end
        end

        for (int i = 0; i < N_CH; i++) begin
            width[i] = MIN_WID + (US_W + 1)'(act_pos_q[i]) * STEP_WID;
            pwm_d[i] = act_en_q[i] && ({1'b0, us_q} < width[i]);
        end

        frame_start_d = (presc_q == '0) && (us_q == '0);
        wr_err_d      = wr_en && !wr_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            us_q          <= '0;
            shd_pos_q     <= '0;
            shd_en_q      <= '0;
            act_pos_q     <= '0;
            act_en_q      <= '0;
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            us_q          <= us_d;
            shd_pos_q     <= shd_pos_d;
            shd_en_q      <= shd_en_d;
            act_pos_q     <= act_pos_d;
            act_en_q      <= act_en_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            wr_err_q      <= wr_err_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;
    assign wr_err      = wr_err_q;
    assign cur_us      = us_q;

endmodule
